display_scheduler: RTL and testbench
====================================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter NREQ, default 3, number of display requesters (2..8).
REQ-002 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (minimum 16).
REQ-003 Parameter HOLD_FRAMES, default 64, full 8-digit frames a grant is held while others wait (minimum 1).
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req  in  NREQ  per-requester display request, level-sensitive.
REQ-007 data  in  NREQ x 16  per-requester value: [15:8] hi field, [7:0] lo field, unsigned binary.
REQ-008 gnt  out  NREQ  one-hot current owner; all-zero when no owner.
REQ-009 AN  out  8  digit anodes, active-low, at most one bit low.
REQ-010 digit  out  4  BCD value of the digit currently selected by AN, for the downstream segment encoder.
REQ-011 busy  out  1  high while the binary-to-BCD converter runs.

Function
REQ-012 Divider counts 0..REFRESH_DIV-1; a tick is the cycle where it equals REFRESH_DIV-1; it then wraps to 0.
REQ-013 3-bit slot index increments on every tick, wrapping 7->0; a frame boundary is a tick where index==7.
REQ-014 Digit map: slot 0/1/2 = lo ones/tens/hundreds; slot 4/5/6 = hi ones/tens/hundreds; slots 3 and 7 always dark.
REQ-015 Leading-zero suppression per field: hundreds dark if 0; tens dark if hundreds and tens both 0; ones always lit.
REQ-016 AN = ~(8'b1 << index) when the slot is lit and the buffer is valid, else 8'hFF; digit = buffer nibble for the slot, 0 when dark.
REQ-017 Arbitration occurs only at frame boundaries; gnt changes on that edge only.
REQ-018 At a boundary, the owner is kept if its req is high and its hold count < HOLD_FRAMES, or if no other req is high.
REQ-019 Otherwise the new owner is the first requester with req high, searching round-robin from owner+1 (from last owner+1 when gnt is zero); gnt goes to zero if none is requesting.
REQ-020 The hold count resets to 1 on each new grant and increments on each boundary the grant is kept, saturating at HOLD_FRAMES.
REQ-021 On the boundary edge, data of the resulting owner is snapshotted; later data changes are ignored until the next boundary.
REQ-022 Converter FSM: IDLE -> CONV at a boundary with an owner.
REQ-023 CONV runs 8 cycles of shift-add-3 (double dabble) on both fields in parallel into two 12-bit BCD registers.
REQ-024 CONV -> COMMIT -> IDLE; COMMIT writes both BCD results into the display buffer in one cycle and sets valid.
REQ-025 busy is high exactly in CONV and COMMIT (9 cycles); the buffer and AN show the previous frame's content until COMMIT.
REQ-026 A boundary with gnt zero clears valid on that edge (display dark) and leaves the FSM in IDLE.
REQ-027 Requester data 255 -> digits 2,5,5; data 0 -> ones 0 only; conversion shall be exact for all 0..255.

Reset
REQ-028 While rst is low: divider 0, index 0, gnt 0, last-owner pointer NREQ-1 (req[0] wins first), hold 0, FSM IDLE, buffer 0, valid 0, AN 8'hFF, digit 0, busy 0.
REQ-029 Reset asserted mid-CONV aborts conversion with no buffer write; after release, the first arbitration happens at the first boundary, 8*REFRESH_DIV cycles later.

Verification (NREQ=3, REFRESH_DIV=16, HOLD_FRAMES=2)
REQ-030 req=001, data[0]=16'h7B05 from reset -> gnt=001 at cycle 128; busy for 9 cycles; AN then shows slots 0 and 4,5,6 lit with digits 5,3,2,1 (hi 123, lo 5); slots 1,2,3,7 dark.
REQ-031 req=111 held -> gnt sequence 001,001,010,010,100,100,001, each entry one frame.
REQ-032 Owner 010 drops req mid-frame while req=101 -> gnt stays 010 until the boundary, then becomes 100.
REQ-033 All req drop -> gnt=000 and AN=8'hFF from the next boundary onward.
REQ-034 data changed during CONV -> committed digits reflect the snapshot value, not the new one.
REQ-035 rst pulsed low during CONV -> all outputs return to reset values immediately and no buffer update occurs.

Source files
------------

// File: rtl/display_scheduler.sv
// display_scheduler
//   Shares one 8-digit multiplexed 7-segment display between NREQ requesters.
//   At each frame boundary (slot index 7 reaching its last refresh tick) a
//   round-robin arbiter with a frame-hold limit picks the owner. It then
//   snapshots the owner's two 8-bit fields and converts both to BCD with a
//   double-dabble FSM. The result is scanned out one digit per slot, with
//   leading zeros suppressed.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset
//   req   : per-requester level request
//   data  : per-requester value, [15:8] hi field, [7:0] lo field
//   gnt   : one-hot current owner, zero when unowned
//   AN    : active-low digit anodes, at most one low
//   digit : BCD nibble for the selected digit, 0 when dark
//   busy  : high while converting/committing
module display_scheduler #(
   parameter int NREQ        = 3,
   parameter int REFRESH_DIV = 100000,
   parameter int HOLD_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0][15:0] data,
   output logic [NREQ-1:0]       gnt,
   output logic [7:0]            AN,
   output logic [3:0]            digit,
   output logic                  busy
);

   localparam int DW = $clog2(REFRESH_DIV);
   localparam int PW = $clog2(NREQ);
   localparam int HW = $clog2(HOLD_FRAMES + 1);
   localparam logic [DW-1:0] DIV_MAX  = DW'(REFRESH_DIV - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);
   localparam logic [PW-1:0] PTR_RST  = PW'(NREQ - 1);

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;
   state_t state_q, state_d;

   logic [DW-1:0]   div_q, div_d;
   logic [2:0]      idx_q;
   logic            tick, boundary;

   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]   ptr_q, ptr_d;   // current owner, or last owner when gnt is zero
   logic [HW-1:0]   hold_q, hold_d;
   logic            keep, found;
   logic [PW-1:0]   cand, scan;

   logic [7:0]      bin_hi_q, bin_lo_q;
   logic [11:0]     bcd_hi_q, bcd_lo_q;
   logic [2:0]      step_q;
   logic [23:0]     buf_q;
   logic            valid_q;

   logic [11:0]     field;
   logic [3:0]      nib;
   logic            lit;

   // One double-dabble iteration: add 3 to any nibble >= 5, then shift in the next bit.
   function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic bit_in);
      logic [11:0] adj;
      adj = bcd;
      for (int unsigned n = 0; n < 3; n++) begin
         if (adj[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
      end
      return {adj[10:0], bit_in};
   endfunction

   assign tick     = (div_q == DIV_MAX);
   assign boundary = tick && (idx_q == 3'd7);
   assign div_d    = tick ? '0 : div_q + DW'(1);
   assign gnt      = gnt_q;

   // Round-robin search starting just after ptr_q; the owner itself is the last candidate.
   always_comb begin
      found = 1'b0;
      cand  = ptr_q;
      scan  = ptr_q;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         scan = PW'((32'(ptr_q) + i) % NREQ);
         if (!found && req[scan]) begin
            found = 1'b1;
            cand  = scan;
         end
      end
   end

   always_comb begin
      keep   = (|gnt_q) && req[ptr_q] &&
               ((hold_q < HOLD_MAX) || ((req & ~gnt_q) == '0));
      gnt_d  = gnt_q;
      ptr_d  = ptr_q;
      hold_d = hold_q;
      if (keep) begin
         if (hold_q < HOLD_MAX) hold_d = hold_q + HW'(1);
      end else if (found) begin
         gnt_d       = '0;
         gnt_d[cand] = 1'b1;
         ptr_d       = cand;
         hold_d      = HW'(1);
      end else begin
         gnt_d  = '0;
         hold_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = (state_q != S_IDLE);
      case (state_q)
         S_IDLE:   if (boundary && (|gnt_d)) state_d = S_CONV;
         S_CONV:   if (step_q == 3'd7) state_d = S_COMMIT;
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q    <= '0;
         idx_q    <= '0;
         gnt_q    <= '0;
         ptr_q    <= PTR_RST;
         hold_q   <= '0;
         bin_hi_q <= '0;
         bin_lo_q <= '0;
         bcd_hi_q <= '0;
         bcd_lo_q <= '0;
         step_q   <= '0;
         buf_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         div_q <= div_d;
         if (tick) idx_q <= idx_q + 3'd1;
         if (boundary) begin
            gnt_q  <= gnt_d;
            ptr_q  <= ptr_d;
            hold_q <= hold_d;
            if (|gnt_d) begin
               bin_hi_q <= data[ptr_d][15:8];
               bin_lo_q <= data[ptr_d][7:0];
               bcd_hi_q <= '0;
               bcd_lo_q <= '0;
               step_q   <= '0;
            end else begin
               valid_q  <= 1'b0;
            end
         end else if (state_q == S_CONV) begin
            bcd_hi_q <= dd_step(bcd_hi_q, bin_hi_q[7]);
            bcd_lo_q <= dd_step(bcd_lo_q, bin_lo_q[7]);
            bin_hi_q <= {bin_hi_q[6:0], 1'b0};
            bin_lo_q <= {bin_lo_q[6:0], 1'b0};
            step_q   <= step_q + 3'd1;
         end else if (state_q == S_COMMIT) begin
            buf_q   <= {bcd_hi_q, bcd_lo_q};
            valid_q <= 1'b1;
         end
      end
   end

   // Slot decode: idx[2] picks the field, idx[1:0] the digit (3 is a blank spacer).
   always_comb begin
      field = idx_q[2] ? buf_q[23:12] : buf_q[11:0];
      lit   = 1'b0;
      nib   = '0;
      case (idx_q[1:0])
         2'd0: begin lit = 1'b1;                                   nib = field[3:0];  end
         2'd1: begin lit = (field[11:8] != '0) || (field[7:4] != '0); nib = field[7:4];  end
         2'd2: begin lit = (field[11:8] != '0);                    nib = field[11:8]; end
         default: begin lit = 1'b0; nib = '0; end
      endcase
      if (lit && valid_q) begin
         AN    = ~(8'b1 << idx_q);
         digit = nib;
      end else begin
         AN    = 8'hFF;
         digit = '0;
      end
   end

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler
//   Self-checking bench for display_scheduler with NREQ=3, REFRESH_DIV=16,
//   HOLD_FRAMES=2 (one frame = 128 clocks). A table of per-frame vectors
//   drives req/data just before each boundary. Each expected owner and
//   display value is queued, then popped and checked after the boundary.
//   Hand-written sequences cover first-grant latency, mid-frame request
//   drop, data change during conversion, and reset during conversion.
module tb_display_scheduler;

   logic             clk;
   logic             rst;
   logic [2:0]       req;
   logic [2:0][15:0] data;
   logic [2:0]       gnt;
   logic [7:0]       AN;
   logic [3:0]       digit;
   logic             busy;

   int unsigned cyc;
   int          total = 0;
   int          bad   = 0;

   typedef struct {
      logic [2:0]  req;
      logic [15:0] d0, d1, d2;
      logic [2:0]  gnt;
   } row_t;

   typedef struct {
      logic [2:0]  gnt;
      logic [15:0] val;
      bit          valid;
   } exp_t;

   row_t rows[11];
   exp_t sb[$];

   display_scheduler #(.NREQ(3), .REFRESH_DIV(16), .HOLD_FRAMES(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .data  (data),
      .gnt   (gnt),
      .AN    (AN),
      .digit (digit),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic goto_pos(input int p);
      int n;
      n = 0;
      while (((cyc % 128) != p) && (n < 256)) begin
         step();
         n++;
      end
      if (n >= 256) begin
         total++;
         bad++;
         $display("FAIL goto_pos: position %0d not reached, got %0d", p, cyc % 128);
      end
   endtask

   // Expected {AN, digit} for slot s from a reference decimal split of the value.
   function automatic logic [11:0] exp_slot(input logic [15:0] v, input bit val, input int s);
      int n, h, t, o;
      bit lit;
      logic [3:0] dg;
      logic [7:0] one, an;
      n = (s >= 4) ? int'(v[15:8]) : int'(v[7:0]);
      h = n / 100;
      t = (n / 10) % 10;
      o = n % 10;
      lit = 1'b0;
      dg  = 4'h0;
      case (s % 4)
         0: begin lit = 1'b1;                  dg = 4'(o); end
         1: begin lit = (h != 0) || (t != 0); dg = 4'(t); end
         2: begin lit = (h != 0);              dg = 4'(h); end
         default: lit = 1'b0;
      endcase
      if (!(val && lit)) return {8'hFF, 4'h0};
      one = 8'd1;
      an  = ~(one << s);
      return {an, dg};
   endfunction

   task automatic check_frame(input string nm, input logic [15:0] v, input bit val);
      for (int s = 0; s < 8; s++) begin
         goto_pos(s * 16 + 10);
         check($sformatf("%s slot%0d AN/digit", nm, s), {20'h0, AN, digit},
               {20'h0, exp_slot(v, val, s)});
      end
   endtask

   initial begin
      exp_t e;
      int   bcnt;

      rows[0]  = '{3'b111, 16'h7B05, 16'hFF00, 16'h0A63, 3'b001};
      rows[1]  = '{3'b111, 16'h7B05, 16'hFF00, 16'h0A63, 3'b010};
      rows[2]  = '{3'b111, 16'h7B05, 16'hFF00, 16'h0A63, 3'b010};
      rows[3]  = '{3'b111, 16'h7B05, 16'hFF00, 16'h0A63, 3'b100};
      rows[4]  = '{3'b111, 16'h7B05, 16'hFF00, 16'h0A63, 3'b100};
      rows[5]  = '{3'b111, 16'h7B05, 16'hFF00, 16'h0A63, 3'b001};
      rows[6]  = '{3'b001, 16'h7B05, 16'hFF00, 16'h0A63, 3'b001};
      rows[7]  = '{3'b001, 16'h0000, 16'hFF00, 16'h0A63, 3'b001};
      rows[8]  = '{3'b000, 16'h0000, 16'hFF00, 16'h0A63, 3'b000};
      rows[9]  = '{3'b100, 16'h0000, 16'hFF00, 16'h0A63, 3'b100};
      rows[10] = '{3'b011, 16'hC864, 16'hFF00, 16'h0A63, 3'b001};

      rst  = 1'b0;
      req  = 3'b000;
      data = '0;
      repeat (3) @(negedge clk);
      check("reset gnt",   {29'h0, gnt},  32'h0);
      check("reset AN",    {24'h0, AN},   32'hFF);
      check("reset digit", {28'h0, digit}, 32'h0);
      check("reset busy",  {31'h0, busy}, 32'h0);

      // First grant lands exactly one frame after reset release.
      req     = 3'b001;
      data[0] = 16'h7B05;
      rst     = 1'b1;
      repeat (127) step();
      check("first gnt before boundary", {29'h0, gnt}, 32'h0);
      step();
      check("first gnt at boundary", {29'h0, gnt}, 32'h1);
      bcnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (busy) bcnt++;
         if (i < 9) step();
      end
      check("busy length", bcnt, 9);
      check("busy low after commit", {31'h0, busy}, 32'h0);
      check_frame("first", 16'h7B05, 1'b1);

      for (int r = 0; r < 11; r++) begin
         goto_pos(124);
         req     = rows[r].req;
         data[0] = rows[r].d0;
         data[1] = rows[r].d1;
         data[2] = rows[r].d2;
         e.gnt   = rows[r].gnt;
         e.valid = 1'b1;
         case (rows[r].gnt)
            3'b001:  e.val = rows[r].d0;
            3'b010:  e.val = rows[r].d1;
            3'b100:  e.val = rows[r].d2;
            default: begin e.val = 16'h0; e.valid = 1'b0; end
         endcase
         sb.push_back(e);
         goto_pos(0);
         e = sb.pop_front();
         check($sformatf("row%0d gnt", r), {29'h0, gnt}, {29'h0, e.gnt});
         check_frame($sformatf("row%0d", r), e.val, e.valid);
      end

      // Owner drops its request mid-frame: grant holds until the boundary.
      goto_pos(124);
      req = 3'b010;
      goto_pos(0);
      check("drop: owner 010", {29'h0, gnt}, 32'h2);
      goto_pos(40);
      req = 3'b101;
      step();
      check("drop: held mid-frame", {29'h0, gnt}, 32'h2);
      goto_pos(127);
      check("drop: held end of frame", {29'h0, gnt}, 32'h2);
      step();
      check("drop: new owner 100", {29'h0, gnt}, 32'h4);

      // Data changed during conversion is not what gets committed.
      goto_pos(124);
      data[2] = 16'h0102;
      goto_pos(0);
      check("snap: gnt kept", {29'h0, gnt}, 32'h4);
      check("snap: busy at boundary", {31'h0, busy}, 32'h1);
      goto_pos(3);
      data[2] = 16'hFFFF;
      check_frame("snap", 16'h0102, 1'b1);

      // Reset during conversion.
      goto_pos(124);
      req = 3'b100;
      goto_pos(0);
      check("rstconv: gnt kept", {29'h0, gnt}, 32'h4);
      goto_pos(4);
      check("rstconv: busy before reset", {31'h0, busy}, 32'h1);
      rst = 1'b0;
      #1;
      check("rstconv gnt",   {29'h0, gnt},  32'h0);
      check("rstconv AN",    {24'h0, AN},   32'hFF);
      check("rstconv digit", {28'h0, digit}, 32'h0);
      check("rstconv busy",  {31'h0, busy}, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (10) step();
      check("rstconv slot0 dark", {24'h0, AN}, 32'hFF);
      check("rstconv busy idle",  {31'h0, busy}, 32'h0);
      repeat (117) step();
      check("rstconv gnt before boundary", {29'h0, gnt}, 32'h0);
      step();
      check("rstconv gnt after boundary", {29'h0, gnt}, 32'h4);
      check_frame("rstconv", 16'hFFFF, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
